// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the RV32 load/store memory access master.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WR_WAIT,
        S_RESP
    } state_t;

    // Only the request fields needed after acceptance are kept.
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/mem_data_align.sv
// Byte/half lane handling: extends loaded lanes and merges sub-word store data into a word.
module mem_data_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{addr_lo, 3'b000} +: 8];
        lane_h = addr_lo[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_BU:   load_data = {24'h0, lane_b};
            F3_HU:   load_data = {16'h0, lane_h};
            default: load_data = word;
        endcase

        merged = word;
        case (funct3[1:0])
            2'b00:   merged[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_master.sv
// Converts byte-addressed RV32 loads/stores into word memory transactions;
// sub-word stores become read-modify-write since the memory has no byte enables.
module mem_access_master
    import mem_access_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 30,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [2:0]                req_funct3,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      resp_valid,
    output logic [31:0]               resp_rdata,
    output logic                      resp_err,
    output logic                      mem_request,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic                      mem_valid,
    input  logic [31:0]               mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t   state, state_d;
    mem_req_t req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                      req_ready_d, resp_valid_d, resp_err_d;
    logic                      mem_request_d, mem_we_d;
    logic [31:0]               resp_rdata_d, mem_wdata_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_d;
    logic [31:0]               load_data, merged;
    logic                      timed_out;

    mem_data_align u_align (
        .funct3    (req_q.funct3),
        .addr_lo   (req_q.addr_lo),
        .word      (mem_rdata),
        .wdata     (req_q.wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    assign timed_out = (cnt_q == TO_LAST);

    always_comb begin
        state_d       = state;
        req_d         = req_q;
        cnt_d         = cnt_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = resp_rdata;
        resp_err_d    = resp_err;
        mem_request_d = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    req_d.we      = req_we;
                    req_d.funct3  = req_funct3;
                    req_d.addr_lo = req_addr[1:0];
                    req_d.wdata   = req_wdata;
                    if (is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0])) begin
                        // Pulse is raised from RESP on the following edge.
                        state_d = S_RESP;
                    end else if (req_we && req_funct3 == F3_W) begin
                        state_d       = S_WR;
                        mem_request_d = 1'b1;
                        mem_we_d      = 1'b1;
                        mem_addr_d    = req_addr[MEM_ADDR_WIDTH+1:2];
                        mem_wdata_d   = req_wdata;
                    end else begin
                        state_d       = S_RD;
                        mem_request_d = 1'b1;
                        mem_addr_d    = req_addr[MEM_ADDR_WIDTH+1:2];
                    end
                end
            end
            S_RD: begin
                state_d = S_RD_WAIT;
                cnt_d   = '0;
            end
            S_RD_WAIT: begin
                if (mem_valid) begin
                    if (req_q.we) begin
                        state_d       = S_WR;
                        mem_request_d = 1'b1;
                        mem_we_d      = 1'b1;
                        mem_wdata_d   = merged;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_data;
                        resp_err_d   = 1'b0;
                    end
                end else if (timed_out) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WR: begin
                state_d = S_WR_WAIT;
                cnt_d   = '0;
            end
            S_WR_WAIT: begin
                if (mem_valid || timed_out) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_err_d   = !mem_valid;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_valid) begin
                    state_d = S_IDLE;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            mem_request <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            state       <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            req_ready   <= req_ready_d;
            resp_valid  <= resp_valid_d;
            resp_rdata  <= resp_rdata_d;
            resp_err    <= resp_err_d;
            mem_request <= mem_request_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
        end
    end

endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- Initiator-side controller that drives the word-addressed memory interface (request/we/addr/data_i in; valid/data_o out) on behalf of the CPU load/store stage.
- Accepts byte-addressed RV32 load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) and converts them to memory transactions.
- The memory has no byte enables, so sub-word stores are done as read-modify-write.
- Sits between the MEM pipeline stage and the data-memory instance; returns one response per accepted request.

Parameters:
- MEM_ADDR_WIDTH, 30, width of the memory word address (word addr = req_addr[MEM_ADDR_WIDTH+1:2]).
- TIMEOUT_CYCLES, 16, maximum cycles in a wait state before aborting with error; must be >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  CPU request present.
- req_ready  output  1  high only in IDLE; request accepted on clk edge where req_valid&&req_ready.
- req_we  input  1  1=store, 0=load.
- req_funct3  input  3  RV32 funct3 size/sign code.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data (low bytes used for SB/SH).
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  load result, extended; 0 for stores/errors.
- resp_err  output  1  misaligned, illegal funct3, or timeout; valid with resp_valid.
- mem_request  output  1  one-cycle transaction request to memory.
- mem_we  output  1  write strobe, qualified by mem_request.
- mem_addr  output  MEM_ADDR_WIDTH  word address.
- mem_wdata  output  32  full word to write.
- mem_valid  input  1  memory response, one cycle after the sampled request.
- mem_rdata  input  32  read word, valid with mem_valid.

Behaviour:
- Reset (async, any state): FSM to IDLE, timeout counter 0, all outputs 0 except req_ready=1.
- All outputs are registered; req_ready = (state==IDLE).
- FSM states: IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP.
- Acceptance edge E0, classified with registered copies of the request:
  - illegal funct3 (loads: 011/110/111; stores: any except 000/001/010) -> RESP, err=1.
  - misaligned (half addr[0]!=0; word addr[1:0]!=0) -> RESP, err=1.
  - load or SB/SH -> RD.
  - SW -> WR.
  - Error paths issue no mem_request.
- RD: mem_request=1, mem_we=0, one cycle, then RD_WAIT.
- WR: mem_request=1, mem_we=1, mem_wdata=merged word (or req_wdata for SW), one cycle, then WR_WAIT.
- mem_request is never high for two consecutive cycles.
- RD_WAIT on mem_valid:
  - load -> RESP; resp_rdata = extracted lane (byte lane addr[1:0], half lane addr[1]); sign-extend for LB/LH, zero-extend for LBU/LHU.
  - SB/SH -> merge the new byte/half into mem_rdata at the lane, then WR.
- WR_WAIT on mem_valid -> RESP; resp_rdata=0.
- Timeout: counter clears on entry to each *_WAIT and increments each wait cycle without mem_valid. Reaching TIMEOUT_CYCLES -> RESP with err=1, rdata=0.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. Response fields hold until the next response.
- Latency from E0 to the resp_valid cycle:
  - error: 1 edge.
  - load / SW: 2 edges with a zero-wait memory.
  - SB/SH: 4 edges.
- mem_valid is ignored in IDLE, RD, WR and RESP, so stale responses after a reset or timeout are dropped.
- No new request is accepted until RESP completes; req_valid held high through this is not double-accepted.

Decomposition:
- Package mem_access_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - state enum localparams.
  - function is_misaligned(funct3, addr[1:0]).
- One combinational sub-module, mem_data_align: given funct3, addr[1:0], word and wdata, produces the extended load value and the merged store word.

Test Plan:
- Mem word 4 = 0xDEADBEEF; LW 0x10 -> one mem_request, mem_addr=4, we=0; resp_valid 2 edges after acceptance; rdata=0xDEADBEEF, err=0.
- Same word; LB 0x13 -> rdata 0xFFFFFFDE. LBU 0x13 -> 0x000000DE. LH 0x12 -> 0xFFFFDEAD. LHU 0x10 -> 0x0000BEEF.
- Word 4 = 0x11223344; SB wdata 0x...AA to 0x11 -> read then write mem_wdata=0x1122AA44; resp 4 edges after acceptance; rdata=0. SW 0x55667788 -> single write, word=0x55667788.
- LH 0x03, LW 0x06, and funct3=011 load -> resp_err=1 one edge after acceptance; mem_request never asserted.
- TIMEOUT_CYCLES=8, mem_valid tied 0 -> resp_err=1 after 8 RD_WAIT cycles; a later mem_valid pulse in IDLE produces no response.
- Assert rst during RD_WAIT -> outputs 0 and req_ready=1 immediately; a late mem_valid is ignored; the next LW completes normally.
